// File: rtl/fd3_dff_clr_set.sv
// fd3_dff_clr_set: rising-edge D flop per bit, async active-low set (wins over clear) and clear, exact 4-state sim semantics.
// Zero-delay capture and force; no flow control, q always driven, no power-up value.
module fd3_dff_clr_set #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic clk_is0;
  logic set_lo;
  logic set_unk;
  logic clr_lo;
  logic clr_unk;

  // case compares 4-state exactly, so x/z levels fall to default and become their own strobes
  always_comb begin
    clk_is0 = 1'b0;
    set_lo  = 1'b0;
    set_unk = 1'b0;
    clr_lo  = 1'b0;
    clr_unk = 1'b0;
    case (clk)
      1'b0:    clk_is0 = 1'b1;
      default: ;
    endcase
    case (set)
      1'b0: set_lo = 1'b1;
      1'b1: begin
        case (clr)
          1'b0:    clr_lo = 1'b1;
          1'b1:    ;
          default: clr_unk = 1'b1;
        endcase
      end
      default: set_unk = 1'b1;
    endcase
  end

  // A capture needs clk to leave exactly 0 and land on exactly 1; x->1 and z->1 never wake this block.
  always_ff @(negedge clk_is0 or posedge set_lo or posedge set_unk or posedge clr_lo or posedge clr_unk) begin
    if (set_lo)
      q <= '1;
    else if (set_unk)
      q <= 'x;
    else if (clr_lo)
      q <= '0;
    else if (clr_unk)
      q <= 'x;
    else if (clk === 1'b1)
      q <= d ^ {WIDTH{1'b0}};
  end

endmodule

// File: tb/tb_fd3_dff_clr_set.sv
// Bench for fd3_dff_clr_set at WIDTH=4: directed scenarios plus random single-input steps against a rule-level model.
module tb_fd3_dff_clr_set;
  localparam int W = 4;

  logic         clk;
  logic         clr;
  logic         set;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] mq;
  int           checks;
  int           errors;
  bit           four_state;

  fd3_dff_clr_set #(.WIDTH(W)) dut (
    .clk(clk),
    .clr(clr),
    .set(set),
    .d  (d),
    .q  (q)
  );

  // Apply new input levels, update the reference from the priority rules, then settle for 1 time unit.
  task automatic drive(input logic nclk, input logic nclr, input logic nset, input logic [W-1:0] nd);
    logic pclk;
    pclk = clk;
    clk  = nclk;
    clr  = nclr;
    set  = nset;
    d    = nd;
    if (nset === 1'b0)
      mq = '1;
    else if (nset !== 1'b1)
      mq = 'x;
    else if (nclr === 1'b0)
      mq = '0;
    else if (nclr !== 1'b1)
      mq = 'x;
    else if (pclk === 1'b0 && nclk === 1'b1)
      for (int i = 0; i < W; i++)
        mq[i] = (nd[i] === 1'b0) ? 1'b0 : ((nd[i] === 1'b1) ? 1'b1 : 1'bx);
    #1;
  endtask

  function automatic logic rand_data_bit();
    int r;
    r = int'($urandom_range(0, 9));
    if (four_state && r == 0) return 1'bx;
    if (four_state && r == 1) return 1'bz;
    return r[0];
  endfunction

  function automatic logic rand_ctl();
    int r;
    r = int'($urandom_range(0, 9));
    if (four_state && r == 0) return 1'bx;
    if (four_state && r == 1) return 1'bz;
    return (r < 4) ? 1'b0 : 1'b1;
  endfunction

  task automatic test_reset();
    if (four_state) begin
      checks++;
      if (q !== 4'bxxxx) begin errors++; $display("FAIL powerup_x: q=%b expected %b", q, 4'bxxxx); end
    end
    drive(1'b0, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL reset_clear: q=%b expected %b", q, 4'b0000); end
  endtask

  task automatic test_control_forcing();
    logic         ck;
    logic [W-1:0] dv;
    ck = four_state ? 1'bx : 1'b0;
    dv = four_state ? 4'bxxxx : 4'b0000;
    if (four_state) begin
      drive(ck, 1'b1, 1'bx, dv);
      checks++;
      if (q !== 4'bxxxx) begin errors++; $display("FAIL set_x: q=%b expected %b", q, 4'bxxxx); end
    end
    drive(ck, 1'b1, 1'b0, dv);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL set_low: q=%b expected %b", q, 4'b1111); end
    drive(ck, 1'b0, 1'b0, dv);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL set_beats_clr: q=%b expected %b", q, 4'b1111); end
    drive(ck, 1'b0, 1'b1, dv);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL set_release_clr_low: q=%b expected %b", q, 4'b0000); end
  endtask

  task automatic test_control_x();
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL set_pulse_low: q=%b expected %b", q, 4'b1111); end
    drive(1'b0, 1'b0, 1'b1, 4'b0000);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL set_pulse_release: q=%b expected %b", q, 4'b0000); end
    if (four_state) begin
      drive(1'b0, 1'bx, 1'b1, 4'b0000);
      checks++;
      if (q !== 4'bxxxx) begin errors++; $display("FAIL clr_x: q=%b expected %b", q, 4'bxxxx); end
      drive(1'b0, 1'b1, 1'b1, 4'b0000);
      checks++;
      if (q !== 4'bxxxx) begin errors++; $display("FAIL clr_x_release_holds: q=%b expected %b", q, 4'bxxxx); end
    end
  endtask

  task automatic test_capture0();
    drive(1'b0, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'b0000);
      checks++;
      if (q !== 4'b0000) begin errors++; $display("FAIL capture0_rise%0d: q=%b expected %b", i, q, 4'b0000); end
      drive(1'b0, 1'b1, 1'b1, 4'b0000);
      checks++;
      if (q !== 4'b0000) begin errors++; $display("FAIL capture0_fall%0d: q=%b expected %b", i, q, 4'b0000); end
    end
  endtask

  task automatic test_xz_clock();
    logic seq [6];
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    if (four_state) begin
      seq = '{1'bx, 1'b0, 1'bz, 1'b0, 1'bx, 1'b1};
      for (int i = 0; i < 6; i++) begin
        drive(seq[i], 1'b1, 1'b1, 4'b1111);
        checks++;
        if (q !== 4'b0000) begin errors++; $display("FAIL xz_clock_step%0d: q=%b expected %b", i, q, 4'b0000); end
      end
    end
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL xz_clock_low_hold: q=%b expected %b", q, 4'b0000); end
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL xz_clock_clean_rise: q=%b expected %b", q, 4'b1111); end
  endtask

  task automatic test_hold1();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'b1111);
      drive(1'b1, 1'b1, 1'b1, 4'b1111);
      checks++;
      if (q !== 4'b1111) begin errors++; $display("FAIL hold1_rise%0d: q=%b expected %b", i, q, 4'b1111); end
    end
    drive(1'b1, 1'b1, 1'b1, 4'b0000);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL hold1_d_change_clk_high: q=%b expected %b", q, 4'b1111); end
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    drive(1'b0, 1'b1, 1'b1, 4'b0000);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL hold1_fall: q=%b expected %b", q, 4'b1111); end
    drive(1'b1, 1'b1, 1'b1, 4'b0000);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL hold1_capture0: q=%b expected %b", q, 4'b0000); end
  endtask

  task automatic test_async_priority();
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    drive(1'b1, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL clr_with_rise: q=%b expected %b", q, 4'b0000); end
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL clr_release_clk_high: q=%b expected %b", q, 4'b0000); end
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL clr_release_fall: q=%b expected %b", q, 4'b0000); end
    drive(1'b1, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL first_rise_after_release: q=%b expected %b", q, 4'b1111); end
  endtask

  task automatic test_width();
    drive(1'b0, 1'b1, 1'b1, 4'b1010);
    drive(1'b1, 1'b1, 1'b1, 4'b1010);
    checks++;
    if (q !== 4'b1010) begin errors++; $display("FAIL width_capture_1010: q=%b expected %b", q, 4'b1010); end
    drive(1'b0, 1'b1, 1'b1, 4'b0101);
    drive(1'b1, 1'b1, 1'b1, 4'b0101);
    checks++;
    if (q !== 4'b0101) begin errors++; $display("FAIL width_capture_0101: q=%b expected %b", q, 4'b0101); end
    drive(1'b1, 1'b1, 1'b0, 4'b0101);
    checks++;
    if (q !== 4'b1111) begin errors++; $display("FAIL width_set: q=%b expected %b", q, 4'b1111); end
    drive(1'b1, 1'b0, 1'b1, 4'b0101);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL width_clr: q=%b expected %b", q, 4'b0000); end
  endtask

  task automatic test_random();
    logic         nclk;
    logic         nclr;
    logic         nset;
    logic [W-1:0] nd;
    drive(1'b0, 1'b1, 1'b1, 4'b0000);
    for (int step = 0; step < 600; step++) begin
      nclk = clk;
      nclr = clr;
      nset = set;
      nd   = d;
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          if (four_state && $urandom_range(0, 7) == 0)
            nclk = ($urandom_range(0, 1) == 0) ? 1'bx : 1'bz;
          else
            nclk = (clk === 1'b0) ? 1'b1 : 1'b0;
        end
        3: nclr = rand_ctl();
        4: nset = rand_ctl();
        default: for (int i = 0; i < W; i++) nd[i] = rand_data_bit();
      endcase
      drive(nclk, nclr, nset, nd);
      checks++;
      if (q !== mq) begin errors++; $display("FAIL random_step%0d: q=%b expected %b", step, q, mq); end
    end
  endtask

  initial begin
    logic probe;
    checks = 0;
    errors = 0;
    probe  = 1'bx;
    four_state = $isunknown(probe);
    mq  = 'x;
    clk = 1'b0;
    clr = 1'b1;
    set = 1'b1;
    d   = '0;
    #1;
    test_reset();
    test_control_forcing();
    test_control_x();
    test_capture0();
    test_xz_clock();
    test_hold1();
    test_async_priority();
    test_width();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
